// File: rtl/rice_bit_packer.sv
// rice_bit_packer: packs variable-length Rice codewords MSB-first into a stream of 16-bit words.
// Optional feature: define RICE_PACKER_BITCOUNT_EN to add oBitCount, the running total of codeword bits.
module rice_bit_packer (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iValid,
    input  logic [15:0] iLSB,
    input  logic [15:0] iBitsUsed,
    input  logic        iFlush,
    output logic        oReady,
    output logic [15:0] oData,
    output logic        oValid,
    output logic        oFlushDone
`ifdef RICE_PACKER_BITCOUNT_EN
    ,
    output logic [31:0] oBitCount
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [15:0] lsb_q, lsb_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] buf_q, buf_d;
    logic [3:0]  fill_q, fill_d;
    logic        flush_pending_q, flush_pending_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        flush_done_q, flush_done_d;
`ifdef RICE_PACKER_BITCOUNT_EN
    logic [31:0] bit_count_q, bit_count_d;
`endif

    logic        busy;
    logic        accept;
    logic [4:0]  w;
    logic [15:0] shamt;
    logic [15:0] shifted;
    logic [15:0] chunk_al;
    logic [31:0] appended;
    logic [4:0]  total;

    assign busy   = (state_q == BUSY);
    assign oReady = !busy || (remaining_q <= 16'd16);
    assign accept = iValid && oReady;

    // Chunk is the top w bits of the remaining field, left-aligned; bits above the
    // stored tail read as the unary zeros.
    always_comb begin
        w = 5'd0;
        if (busy) begin
            w = (remaining_q > 16'd16) ? 5'd16 : remaining_q[4:0];
        end
        shamt    = remaining_q - {11'd0, w};
        shifted  = lsb_q >> shamt;
        chunk_al = shifted << (5'd16 - w);
        appended = buf_q | ({chunk_al, 16'h0000} >> fill_q);
        total    = {1'b0, fill_q} + w;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d         = state_q;
        lsb_d           = lsb_q;
        remaining_d     = remaining_q;
        buf_d           = buf_q;
        fill_d          = fill_q;
        flush_pending_d = flush_pending_q | iFlush;
        data_d          = data_q;
        valid_d         = 1'b0;
        flush_done_d    = 1'b0;
`ifdef RICE_PACKER_BITCOUNT_EN
        bit_count_d     = bit_count_q;
`endif

        if (busy) begin
            remaining_d = remaining_q - {11'd0, w};
            fill_d      = total[3:0];
            if (total >= 5'd16) begin
                data_d  = appended[31:16];
                valid_d = 1'b1;
                buf_d   = {appended[15:0], 16'h0000};
            end else begin
                buf_d   = appended;
            end
            if (remaining_d == 16'd0) begin
                state_d = IDLE;
            end
`ifdef RICE_PACKER_BITCOUNT_EN
            bit_count_d = bit_count_q + {27'd0, w};
`endif
        end

        if (accept) begin
            lsb_d       = iLSB;
            remaining_d = iBitsUsed;
            state_d     = (iBitsUsed != 16'd0) ? BUSY : IDLE;
        end else if (!busy && flush_pending_q) begin
            // Buffer bits below fill are always zero, so the top half is already padded.
            if (fill_q != 4'd0) begin
                data_d  = buf_q[31:16];
                valid_d = 1'b1;
            end
            buf_d           = 32'd0;
            fill_d          = 4'd0;
            flush_done_d    = 1'b1;
            flush_pending_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q         <= IDLE;
            lsb_q           <= 16'd0;
            remaining_q     <= 16'd0;
            buf_q           <= 32'd0;
            fill_q          <= 4'd0;
            flush_pending_q <= 1'b0;
            data_q          <= 16'd0;
            valid_q         <= 1'b0;
            flush_done_q    <= 1'b0;
`ifdef RICE_PACKER_BITCOUNT_EN
            bit_count_q     <= 32'd0;
`endif
        end else begin
            state_q         <= state_d;
            lsb_q           <= lsb_d;
            remaining_q     <= remaining_d;
            buf_q           <= buf_d;
            fill_q          <= fill_d;
            flush_pending_q <= flush_pending_d;
            data_q          <= data_d;
            valid_q         <= valid_d;
            flush_done_q    <= flush_done_d;
`ifdef RICE_PACKER_BITCOUNT_EN
            bit_count_q     <= bit_count_d;
`endif
        end
    end

    assign oData      = data_q;
    assign oValid     = valid_q;
    assign oFlushDone = flush_done_q;
`ifdef RICE_PACKER_BITCOUNT_EN
    assign oBitCount  = bit_count_q;
`endif

endmodule

// File: tb/tb_rice_bit_packer.sv
// Testbench for rice_bit_packer: directed cases plus randomized codewords checked against
// a bit-queue reference model of the packed stream.
module tb_rice_bit_packer;

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic        iValid = 1'b0;
    logic [15:0] iLSB = 16'd0;
    logic [15:0] iBitsUsed = 16'd0;
    logic        iFlush = 1'b0;
    logic        oReady;
    logic [15:0] oData;
    logic        oValid;
    logic        oFlushDone;
`ifdef RICE_PACKER_BITCOUNT_EN
    logic [31:0] oBitCount;
`endif

    rice_bit_packer dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iValid     (iValid),
        .iLSB       (iLSB),
        .iBitsUsed  (iBitsUsed),
        .iFlush     (iFlush),
        .oReady     (oReady),
        .oData      (oData),
        .oValid     (oValid),
        .oFlushDone (oFlushDone)
`ifdef RICE_PACKER_BITCOUNT_EN
        ,
        .oBitCount  (oBitCount)
`endif
    );

    always #5 iClock = ~iClock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the stream as a queue of bits; every 16 bits become one expected word.
    bit          bits_q[$];
    logic [15:0] exp_q[$];
    int          fd_exp = 0;
    int          fd_seen = 0;
    logic [31:0] bit_sum = 0;

    task automatic model_drain();
        logic [15:0] word;
        while (bits_q.size() >= 16) begin
            word = 16'd0;
            for (int k = 0; k < 16; k++) word = {word[14:0], bits_q.pop_front()};
            exp_q.push_back(word);
        end
    endtask

    task automatic model_push(input int len, input logic [15:0] lsb);
        for (int i = len - 1; i >= 0; i--) bits_q.push_back((i < 16) ? lsb[i] : 1'b0);
        bit_sum = bit_sum + len;
        model_drain();
    endtask

    task automatic model_flush();
        if (bits_q.size() > 0) begin
            while (bits_q.size() < 16) bits_q.push_back(1'b0);
            model_drain();
        end
        fd_exp++;
    endtask

    task automatic model_reset();
        bits_q.delete();
        exp_q.delete();
        bit_sum = 0;
    endtask

    always @(negedge iClock) begin
        logic [15:0] e;
        if (!iReset) begin
            if (oValid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {31'd0, oValid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {16'd0, oData}, {16'd0, e});
                end
            end
            if (oFlushDone) fd_seen++;
        end
    end

    // Presents one codeword; returns after the accepting edge (+1) with the number of stall cycles.
    task automatic send(input int len, input logic [15:0] lsb, input logic fl, output int waits);
        iValid    = 1'b1;
        iLSB      = lsb;
        iBitsUsed = len[15:0];
        iFlush    = 1'b0;
        waits     = 0;
        while (!oReady && waits < 100) begin
            @(posedge iClock); #1;
            waits++;
        end
        if (waits >= 100) check("ready_timeout", {31'd0, oReady}, 32'd1);
        iFlush = fl;
        model_push(len, lsb);
        if (fl) model_flush();
        @(posedge iClock); #1;
        iValid = 1'b0;
        iFlush = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (fd_seen < fd_exp && n < 200) begin
            @(posedge iClock); #1;
            n++;
        end
        @(posedge iClock); #1;
        check(tag, fd_seen, fd_exp);
    endtask

    task automatic flush_only(input string tag);
        iFlush = 1'b1;
        model_flush();
        @(posedge iClock); #1;
        iFlush = 1'b0;
        wait_done(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          w;
        logic [15:0] d;
        int          len;
        int          r;
        logic        fl;

        repeat (3) @(posedge iClock);
        #1;
        check("rst_ready", {31'd0, oReady}, 32'd1);
        check("rst_valid", {31'd0, oValid}, 32'd0);
        check("rst_data", {16'd0, oData}, 32'd0);
        check("rst_fdone", {31'd0, oFlushDone}, 32'd0);
`ifdef RICE_PACKER_BITCOUNT_EN
        check("rst_bitcount", oBitCount, 32'd0);
`endif
        iReset = 1'b0;
        @(posedge iClock); #1;

        send(3, 16'h0005, 1'b0, w);
        flush_only("flush_a000");

        for (int i = 0; i < 16; i++) begin
            send(1, 16'h0001, 1'b0, w);
            check("ones_no_stall", w, 0);
        end
        check("ones_not_yet", {31'd0, oValid}, 32'd0);
        @(posedge iClock); #1;
        check("ones_valid", {31'd0, oValid}, 32'd1);
        check("ones_data", {16'd0, oData}, 32'h0000FFFF);

        send(23, 16'h0006, 1'b0, w);
        check("long_ready_low", {31'd0, oReady}, 32'd0);
        @(posedge iClock); #1;
        check("long_ready_high", {31'd0, oReady}, 32'd1);
        flush_only("flush_long");
`ifdef RICE_PACKER_BITCOUNT_EN
        check("bitcount_long", oBitCount, bit_sum);
`endif

        d = oData;
        flush_only("flush_empty");
        check("empty_flush_data", {16'd0, oData}, {16'd0, d});

        send(16, 16'h8001, 1'b1, w);
        wait_done("flush_same_cycle");

        send(40, 16'hBEEF, 1'b0, w);
        @(posedge iClock); #1;
        @(negedge iClock); #1;
        iReset = 1'b1;
        model_reset();
        @(posedge iClock); #1;
        check("midreset_ready", {31'd0, oReady}, 32'd1);
        check("midreset_valid", {31'd0, oValid}, 32'd0);
`ifdef RICE_PACKER_BITCOUNT_EN
        check("midreset_bitcount", oBitCount, 32'd0);
`endif
        iReset = 1'b0;
        @(posedge iClock); #1;
        send(3, 16'h0005, 1'b0, w);
        flush_only("flush_after_reset");

        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge iClock); #1;
            end
            r = $urandom_range(0, 9);
            if (r == 0)      len = 0;
            else if (r <= 6) len = $urandom_range(1, 16);
            else if (r <= 8) len = $urandom_range(17, 40);
            else             len = $urandom_range(41, 70);
            fl = ($urandom_range(0, 11) == 0);
            send(len, 16'($urandom), fl, w);
            if (fl) wait_done("rand_flush");
            if ($urandom_range(0, 29) == 0) flush_only("rand_flush_only");
        end
        flush_only("final_flush");
        repeat (20) @(posedge iClock);
        #1;
        check("words_left", exp_q.size(), 0);
        check("flush_count", fd_seen, fd_exp);
`ifdef RICE_PACKER_BITCOUNT_EN
        check("bitcount_final", oBitCount, bit_sum);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
